// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// State encoding, default baud divisor and counter sizing helper.
package uart_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_POP    = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_PARITY = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = S_IDLE,
        POP    = S_POP,
        LOAD   = S_LOAD,
        START  = S_START,
        DATA   = S_DATA,
        PARITY = S_PARITY,
        STOP   = S_STOP
    } state_t;

    localparam int CLKS_PER_BIT_DEF = 868;

    function automatic int baud_width(input int cpb);
        int w;
        w = $clog2(cpb);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle
// of each bit; held at zero while clear is high.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int W            = baud_width(CLKS_PER_BIT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         tick
);

    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    assign tick = !clear && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the single-clock byte FIFO and shifts each one out
// LSB-first as a UART frame with optional even parity.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frames_sent
);

    localparam int W = baud_width(CLKS_PER_BIT);
    localparam logic [W-1:0] PENULT = W'(CLKS_PER_BIT - 2);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    state_t       state;
    logic [7:0]   shift;
    logic         par;
    logic [2:0]   idx;
    logic [W-1:0] count;
    logic         tick;
    logic         clear;

    // The divider only runs while a bit is on the line, so it is
    // already at zero on the first cycle of START.
    assign clear = (state == IDLE) || (state == POP) || (state == LOAD);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .W            (W)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .count (count),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tx          <= 1'b1;
            fifo_rd_en  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frames_sent <= '0;
            idx         <= '0;
            shift       <= '0;
            par         <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_enable && !fifo_empty) begin
                        state      <= POP;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                POP: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shift <= fifo_dout;
                    par   <= ^fifo_dout;
                    idx   <= '0;
                    tx    <= 1'b0;
                    state <= START;
                end
                START: begin
                    if (tick) begin
                        tx    <= shift[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (idx == 3'd7) begin
                            idx <= '0;
                            if (PARITY_EN != 0) begin
                                tx    <= par;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            idx   <= idx + 3'd1;
                            shift <= shift >> 1;
                            tx    <= shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Registered pulse: raise it one cycle early so it
                    // lands on the final stop cycle.
                    if (idx == LAST_STOP && count == PENULT) begin
                        frame_done  <= 1'b1;
                        frames_sent <= frames_sent + 16'd1;
                    end
                    if (tick) begin
                        if (idx == LAST_STOP) begin
                            idx   <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (plain 8N1 and 8E2) fed by
// FIFO models, frames compared against a bit-list reference.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  en_v;
    logic [1:0]  empty_v;
    logic [7:0]  dout0;
    logic [7:0]  dout1;
    logic [1:0]  rd_v;
    logic [1:0]  tx_v;
    logic [1:0]  busy_v;
    logic [1:0]  done_v;
    logic [15:0] fs0;
    logic [15:0] fs1;

    logic [7:0]  mem [2][256];
    int          pushed [2];
    int          popped0;
    int          popped1;
    int          exp_frames [2];
    int          checks;
    int          errors;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .PARITY_EN    (0),
        .STOP_BITS    (1)
    ) dut0 (
        .clk         (clk),
        .rst         (rst),
        .tx_enable   (en_v[0]),
        .fifo_empty  (empty_v[0]),
        .fifo_dout   (dout0),
        .fifo_rd_en  (rd_v[0]),
        .tx          (tx_v[0]),
        .busy        (busy_v[0]),
        .frame_done  (done_v[0]),
        .frames_sent (fs0)
    );

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .PARITY_EN    (1),
        .STOP_BITS    (2)
    ) dut1 (
        .clk         (clk),
        .rst         (rst),
        .tx_enable   (en_v[1]),
        .fifo_empty  (empty_v[1]),
        .fifo_dout   (dout1),
        .fifo_rd_en  (rd_v[1]),
        .tx          (tx_v[1]),
        .busy        (busy_v[1]),
        .frame_done  (done_v[1]),
        .frames_sent (fs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign empty_v[0] = (pushed[0] == popped0);
    assign empty_v[1] = (pushed[1] == popped1);

    // Registered FIFO read port; junk on the bus whenever not popping.
    always @(posedge clk) begin
        if (rd_v[0] && pushed[0] != popped0) begin
            dout0   <= mem[0][popped0 % 256];
            popped0 <= popped0 + 1;
        end else begin
            dout0 <= 8'($urandom);
        end
    end

    always @(posedge clk) begin
        if (rd_v[1] && pushed[1] != popped1) begin
            dout1   <= mem[1][popped1 % 256];
            popped1 <= popped1 + 1;
        end else begin
            dout1 <= 8'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int sel, input logic [7:0] b);
        mem[sel][pushed[sel] % 256] = b;
        pushed[sel] = pushed[sel] + 1;
    endtask

    function automatic logic [15:0] fs_of(input int sel);
        return (sel == 0) ? fs0 : fs1;
    endfunction

    task automatic check_frame(input int sel, input logic [7:0] b,
                               input bit b2b, input bit drop_en);
        bit exp_q[$];
        int waited;
        int total;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!rd_v[sel] && waited < 60);
        chk("pop_seen", 32'(rd_v[sel]), 32'd1);
        if (!rd_v[sel]) return;
        if (b2b) chk("gap", 32'(waited), 32'd1);
        chk("pop_tx", 32'(tx_v[sel]), 32'd1);
        @(negedge clk);
        chk("load_tx", 32'(tx_v[sel]), 32'd1);
        chk("load_rd", 32'(rd_v[sel]), 32'd0);
        chk("load_busy", 32'(busy_v[sel]), 32'd1);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        if (sel == 1) exp_q.push_back(($countones(b) % 2) == 1);
        exp_q.push_back(1'b1);
        if (sel == 1) exp_q.push_back(1'b1);
        total = exp_q.size() * CPB;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            if (drop_en && k == 0) en_v[sel] = 1'b0;
            chk("tx_bit", 32'(tx_v[sel]), 32'(exp_q[k / CPB]));
            chk("frame_done", 32'(done_v[sel]), 32'(k == total - 1));
            chk("rd_quiet", 32'(rd_v[sel]), 32'd0);
            chk("busy_frame", 32'(busy_v[sel]), 32'd1);
        end
        exp_frames[sel] = (exp_frames[sel] + 1) % 65536;
        @(negedge clk);
        chk("idle_tx", 32'(tx_v[sel]), 32'd1);
        chk("idle_busy", 32'(busy_v[sel]), 32'd0);
        chk("idle_done", 32'(done_v[sel]), 32'd0);
        chk("frames_sent", 32'(fs_of(sel)), 32'(exp_frames[sel]));
    endtask

    initial begin
        logic [7:0] rb [$];
        int n;
        int waited;
        checks = 0;
        errors = 0;
        pushed[0] = 0;
        pushed[1] = 0;
        popped0 = 0;
        popped1 = 0;
        exp_frames[0] = 0;
        exp_frames[1] = 0;
        en_v = 2'b00;
        rst = 1'b1;
        #1;
        chk("rst_tx", 32'(tx_v), 32'h3);
        chk("rst_rd", 32'(rd_v), 32'h0);
        chk("rst_busy", 32'(busy_v), 32'h0);
        chk("rst_done", 32'(done_v), 32'h0);
        chk("rst_fs0", 32'(fs0), 32'h0);
        chk("rst_fs1", 32'(fs1), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        push(0, 8'hA5);
        en_v[0] = 1'b1;
        check_frame(0, 8'hA5, 1'b0, 1'b0);

        push(0, 8'h01);
        push(0, 8'h02);
        push(0, 8'h03);
        check_frame(0, 8'h01, 1'b0, 1'b0);
        check_frame(0, 8'h02, 1'b1, 1'b0);
        check_frame(0, 8'h03, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("drained_busy", 32'(busy_v[0]), 32'd0);
        chk("drained_fs", 32'(fs0), 32'd4);

        n = $urandom_range(4, 7);
        for (int i = 0; i < n; i++) begin
            rb.push_back(8'($urandom));
            push(0, rb[i]);
        end
        for (int i = 0; i < n; i++) check_frame(0, rb[i], i > 0, 1'b0);

        push(1, 8'h07);
        push(1, 8'($urandom));
        en_v[1] = 1'b1;
        check_frame(1, 8'h07, 1'b0, 1'b0);
        check_frame(1, mem[1][1], 1'b1, 1'b0);
        en_v[1] = 1'b0;

        for (int i = 0; i < 100; i++) begin
            en_v[0] = 1'($urandom);
            @(negedge clk);
            chk("empty_rd", 32'(rd_v[0]), 32'd0);
            chk("empty_tx", 32'(tx_v[0]), 32'd1);
            chk("empty_busy", 32'(busy_v[0]), 32'd0);
        end

        en_v[0] = 1'b1;
        push(0, 8'h9E);
        push(0, 8'h61);
        check_frame(0, 8'h9E, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("held_rd", 32'(rd_v[0]), 32'd0);
            chk("held_empty", 32'(empty_v[0]), 32'd0);
        end
        en_v[0] = 1'b1;
        check_frame(0, 8'h61, 1'b0, 1'b0);

        push(0, 8'h55);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!rd_v[0] && waited < 60);
        chk("rst_pop_seen", 32'(rd_v[0]), 32'd1);
        repeat (18) @(negedge clk);
        chk("bit3_tx", 32'(tx_v[0]), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx_v[0]), 32'd1);
        chk("midrst_busy", 32'(busy_v[0]), 32'd0);
        chk("midrst_fs", 32'(fs0), 32'd0);
        exp_frames[0] = 0;
        exp_frames[1] = 0;
        @(negedge clk);
        rst = 1'b0;
        push(0, 8'h3C);
        check_frame(0, 8'h3C, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
